tff_count_ctrl: RTL and testbench

Controller that sequences a bank of WIDTH T flip-flop bit cells as a programmable-modulus up/down counter. It computes each cell's T input from the current state and the requested next value, and runs a start/stop/clear FSM around the bank. It sits between software-style control strobes and the toggle-flop datapath, and is the only block that drives the cells' T inputs.

---
 rtl/tff_count_ctrl_pkg.sv | 15 +
 rtl/tff_count_ctrl_if.sv | 28 ++
 rtl/tff_count_ctrl_cell.sv | 31 +++
 rtl/tff_count_ctrl.sv | 146 ++++++++++++++
 tb/tb_tff_count_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/tff_count_ctrl_pkg.sv
// Shared definitions for the T flip-flop counter controller.
//   state_t  : FSM state encoding (ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2)
//   DIR_UP / DIR_DOWN : count direction encodings
package tff_count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_count_ctrl_if.sv
// Control/status bundle between a software-style controller and the
// T flip-flop counter.
//   master : drives start/stop/clear/dir/modulus, observes count/busy/wrap
//   slave  : the counter block itself
interface tff_count_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic             stop;
  logic             clear;
  logic             dir;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             wrap;

  modport master (
    output start, stop, clear, dir, modulus,
    input  count, busy, wrap
  );

  modport slave (
    input  start, stop, clear, dir, modulus,
    output count, busy, wrap
  );

endinterface

// File: rtl/tff_count_ctrl_cell.sv
// Single T flip-flop bit cell (module tff_cell).
//   t    : toggle enable, q flips on the rising clk edge when high
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears q to 0
//   q    : stored bit
//   qbar : complement of q
module tff_cell (
  input  logic t,
  input  logic clk,
  input  logic rst,
  output logic q,
  output logic qbar
);

  logic q_r;

  // Toggle storage bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= 1'b0;
    end else if (t) begin
      q_r <= ~q_r;
    end else begin
      q_r <= q_r;
    end
  end

  assign q    = q_r;
  assign qbar = ~q_r;

endmodule

// File: rtl/tff_count_ctrl.sv
// Programmable-modulus up/down counter built from WIDTH T flip-flop cells.
// The controller computes the desired next value and drives each cell's T
// input with q ^ nxt, so every value change is made by toggling.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   ctl  : slave side of tff_count_ctrl_if
//          start/stop/clear strobes, dir/modulus (sampled on start from IDLE),
//          count (cell Q outputs), busy (RUN or PAUSE), wrap (registered pulse)
module tff_count_ctrl
  import tff_count_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  tff_count_ctrl_if.slave    ctl
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic             dir_r;
  logic [WIDTH-1:0] mod_r;
  logic             wrap_r;
  logic             busy_r;

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] qbar_s;
  logic [WIDTH-1:0] nxt_s;
  logic [WIDTH-1:0] t_s;
  logic [WIDTH-1:0] mod_last_s;
  logic [WIDTH-1:0] init_s;
  logic             wrap_s;
  logic             load_s;
  logic             at_zero_s;

  // modulus 0 wraps naturally: 0 - 1 is all-ones
  assign mod_last_s = mod_r - ONE;
  // Initial value uses the live inputs because they are latched on this edge
  assign init_s     = (ctl.dir == DIR_DOWN) ? (ctl.modulus - ONE) : ZERO;
  // All complement outputs high means the bank holds zero
  assign at_zero_s  = &qbar_s;

  // Next-state, next-count and wrap decode
  always_comb begin
    state_nxt_s = state_r;
    nxt_s       = q_s;
    wrap_s      = 1'b0;
    load_s      = 1'b0;
    if (ctl.clear) begin
      state_nxt_s = ST_IDLE;
      nxt_s       = ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          nxt_s = ZERO;
          if (ctl.start) begin
            load_s      = 1'b1;
            nxt_s       = init_s;
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (ctl.stop) begin
            nxt_s       = q_s;
            state_nxt_s = ST_PAUSE;
          end else if (dir_r == DIR_DOWN) begin
            if (at_zero_s) begin
              nxt_s  = mod_last_s;
              wrap_s = 1'b1;
            end else begin
              nxt_s = q_s - ONE;
            end
          end else begin
            if (q_s == mod_last_s) begin
              nxt_s  = ZERO;
              wrap_s = 1'b1;
            end else begin
              nxt_s = q_s + ONE;
            end
          end
        end
        ST_PAUSE: begin
          nxt_s = q_s;
          if (ctl.start) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PAUSE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          nxt_s       = ZERO;
        end
      endcase
    end
  end

  assign t_s = q_s ^ nxt_s;

  // FSM state, busy and wrap registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      wrap_r  <= wrap_s;
    end
  end

  // Direction and modulus captured only on start from IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_r <= DIR_UP;
      mod_r <= ZERO;
    end else if (load_s) begin
      dir_r <= ctl.dir;
      mod_r <= ctl.modulus;
    end else begin
      dir_r <= dir_r;
      mod_r <= mod_r;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .t    (t_s[i]),
      .clk  (clk),
      .rst  (rst),
      .q    (q_s[i]),
      .qbar (qbar_s[i])
    );
  end

  assign ctl.count = q_s;
  assign ctl.busy  = busy_r;
  assign ctl.wrap  = wrap_r;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed testbench for tff_count_ctrl with WIDTH = 4.
module tb_tff_count_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  tff_count_ctrl_if #(.WIDTH(4)) bus ();

  tff_count_ctrl #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int c, input bit w, input bit b);
    check({tag, "_count"}, {28'd0, bus.count}, c);
    check({tag, "_wrap"},  {31'd0, bus.wrap},  {31'd0, w});
    check({tag, "_busy"},  {31'd0, bus.busy},  {31'd0, b});
  endtask

  task automatic strobes(input bit s, input bit p, input bit c);
    bus.start = s;
    bus.stop  = p;
    bus.clear = c;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    strobes(1'b0, 1'b0, 1'b0);
    bus.dir     = 1'b0;
    bus.modulus = 4'd0;

    // reset state, then release with no start
    tick();
    expect_out("reset", 0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    expect_out("idle_no_start", 0, 1'b0, 1'b0);

    // up, modulus 5
    bus.dir = 1'b0; bus.modulus = 4'd5; strobes(1'b1, 1'b0, 1'b0);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    expect_out("up5_start", 0, 1'b0, 1'b1);
    begin
      int exp_c [6] = '{1, 2, 3, 4, 0, 1};
      bit exp_w [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 6; k++) begin
        tick();
        expect_out($sformatf("up5_s%0d", k), exp_c[k], exp_w[k], 1'b1);
      end
    end
    strobes(1'b0, 1'b0, 1'b1);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    expect_out("clear1", 0, 1'b0, 1'b0);

    // down, modulus 0 (16); dir/modulus changes mid-run must be ignored
    bus.dir = 1'b1; bus.modulus = 4'd0; strobes(1'b1, 1'b0, 1'b0);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    expect_out("dn16_start", 15, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        bus.dir = 1'b0;
        bus.modulus = 4'd3;
      end
      tick();
      expect_out($sformatf("dn16_s%0d", k), (16 + 15 - k) % 16, (k == 16), 1'b1);
    end
    strobes(1'b0, 1'b0, 1'b1);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    expect_out("clear2", 0, 1'b0, 1'b0);

    // pause / resume, up modulus 10
    bus.dir = 1'b0; bus.modulus = 4'd10; strobes(1'b1, 1'b0, 1'b0);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      expect_out($sformatf("m10_s%0d", k), k, 1'b0, 1'b1);
    end
    strobes(1'b0, 1'b1, 1'b0);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    expect_out("pause0", 6, 1'b0, 1'b1);
    tick();
    expect_out("pause1", 6, 1'b0, 1'b1);
    tick();
    expect_out("pause2", 6, 1'b0, 1'b1);
    strobes(1'b1, 1'b0, 1'b0);
    tick();
    expect_out("resume_edge", 6, 1'b0, 1'b1);
    tick();
    expect_out("resume7", 7, 1'b0, 1'b1);
    tick();
    expect_out("resume8", 8, 1'b0, 1'b1);
    tick();
    expect_out("resume9", 9, 1'b0, 1'b1);
    tick();
    expect_out("resume0", 0, 1'b1, 1'b1);
    strobes(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    expect_out("pre_prio", 3, 1'b0, 1'b1);

    // clear + stop + start together: clear wins
    strobes(1'b1, 1'b1, 1'b1);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    expect_out("prio", 0, 1'b0, 1'b0);
    tick();
    expect_out("prio_idle", 0, 1'b0, 1'b0);

    // modulus 1: stuck at 0, wrap every RUN cycle
    bus.dir = 1'b0; bus.modulus = 4'd1; strobes(1'b1, 1'b0, 1'b0);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    expect_out("m1_start", 0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      expect_out($sformatf("m1_s%0d", k), 0, 1'b1, 1'b1);
    end
    strobes(1'b0, 1'b0, 1'b1);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    expect_out("clear3", 0, 1'b0, 1'b0);

    // asynchronous reset mid-run
    bus.dir = 1'b0; bus.modulus = 4'd0; strobes(1'b1, 1'b0, 1'b0);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    expect_out("pre_rst", 3, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    expect_out("async_rst", 0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    expect_out("post_rst", 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
